// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per cycle).
// A request with any non-decimal digit skips conversion and reports err with a zero result.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BCD_W-1:0]       bcd_corr;
    logic [BIN_W-1:0]       bin_shift;
    logic                   last_iter;
    logic                   accept;
    logic                   in_valid;

    function automatic logic digits_valid(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Undo the add-3 step of double-dabble: a digit that reached 8+ after the shift held a carry.
    function automatic logic [BCD_W-1:0] sub3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    assign shifted   = {bcd_reg, bin_reg} >> 1;
    assign bcd_shift = shifted[BIN_W +: BCD_W];
    assign bin_shift = shifted[BIN_W-1:0];
    assign bcd_corr  = sub3_digits(bcd_shift);
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));
    assign in_valid  = digits_valid(bcd_in);
    assign accept    = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = in_valid ? CONV : DONE;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = in_valid ? CONV : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (in_valid) begin
                    bcd_reg <= bcd_in;
                    bin_reg <= '0;
                    cnt     <= '0;
                end else begin
                    bin_out <= '0;
                    err     <= 1'b1;
                end
            end else if (state == CONV) begin
                bcd_reg <= bcd_corr;
                bin_reg <= bin_shift;
                cnt     <= cnt + CNT_W'(1);
                if (last_iter) begin
                    bin_out <= bin_shift;
                    err     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: default 4-digit instance plus a 2-digit/7-bit instance.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    logic        start2;
    logic [7:0]  bcd_in2;
    logic        busy2;
    logic        done2;
    logic [6:0]  bin_out2;
    logic        err2;

    int checks;
    int errors;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd_in2),
        .busy(busy2), .done(done2), .bin_out(bin_out2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start for one cycle; returns at the negedge of the cycle after the start cycle.
    task automatic send(input logic [15:0] v);
        start  = 1'b1;
        bcd_in = v;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Latency counted in cycles from the start cycle (cycle 0); n0 is the current cycle index.
    task automatic wait_done(input int n0, output int lat, output logic [13:0] res,
                             output logic e, output int busy_cycles);
        lat = -1;
        res = '0;
        e = 1'b0;
        busy_cycles = 0;
        for (int n = n0; n < n0 + 40; n++) begin
            if (done) begin
                lat = n;
                res = bin_out;
                e = err;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_conv(input logic [15:0] v, output int lat, output logic [13:0] res,
                            output logic e, output int busy_cycles);
        @(negedge clk);
        send(v);
        wait_done(1, lat, res, e, busy_cycles);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (bin_out !== 14'h0) begin errors++; $display("FAIL reset_bin: got %h expected 0", bin_out); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        if ({busy2, done2, bin_out2, err2} !== 10'h0) begin
            errors++; $display("FAIL reset_dut2: got %h expected 0", {busy2, done2, bin_out2, err2});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_max;
        int lat, bc;
        logic [13:0] res;
        logic e;
        run_conv(16'h9999, lat, res, e, bc);
        checks += 4;
        if (lat !== 15) begin errors++; $display("FAIL max_latency: got %0d expected 15", lat); end
        if (res !== 14'h270F) begin errors++; $display("FAIL max_value: got %h expected 270f", res); end
        if (e !== 1'b0) begin errors++; $display("FAIL max_err: got %b expected 0", e); end
        if (bc !== 14) begin errors++; $display("FAIL max_busy: got %0d expected 14", bc); end
    endtask

    task automatic test_values;
        int lat, bc;
        logic [13:0] res;
        logic e;
        run_conv(16'h1234, lat, res, e, bc);
        checks += 3;
        if (res !== 14'h04D2) begin errors++; $display("FAIL v1234_value: got %h expected 04d2", res); end
        if (lat !== 15) begin errors++; $display("FAIL v1234_latency: got %0d expected 15", lat); end
        if (bc !== 14) begin errors++; $display("FAIL v1234_busy: got %0d expected 14", bc); end
        run_conv(16'h0000, lat, res, e, bc);
        checks += 3;
        if (res !== 14'h0000) begin errors++; $display("FAIL v0000_value: got %h expected 0000", res); end
        if (bc !== 14) begin errors++; $display("FAIL v0000_busy: got %0d expected 14", bc); end
        if (e !== 1'b0) begin errors++; $display("FAIL v0000_err: got %b expected 0", e); end
    endtask

    task automatic test_invalid;
        int lat, bc;
        logic [13:0] res;
        logic e;
        run_conv(16'h12A4, lat, res, e, bc);
        checks += 4;
        if (lat !== 1) begin errors++; $display("FAIL inv_latency: got %0d expected 1", lat); end
        if (e !== 1'b1) begin errors++; $display("FAIL inv_err: got %b expected 1", e); end
        if (res !== 14'h0) begin errors++; $display("FAIL inv_value: got %h expected 0000", res); end
        if (bc !== 0) begin errors++; $display("FAIL inv_busy: got %0d expected 0", bc); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL inv_done_pulse: got %b expected 0", done); end
        if (err !== 1'b1) begin errors++; $display("FAIL inv_err_hold: got %b expected 1", err); end
        run_conv(16'h0042, lat, res, e, bc);
        checks += 2;
        if (e !== 1'b0) begin errors++; $display("FAIL inv_clear_err: got %b expected 0", e); end
        if (res !== 14'h002A) begin errors++; $display("FAIL inv_next_value: got %h expected 002a", res); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic [13:0] res;
        logic e;
        @(negedge clk);
        send(16'h0025);
        repeat (4) @(negedge clk);
        send(16'h9999);
        bcd_in = 16'h8888;
        wait_done(6, lat, res, e, bc);
        checks += 2;
        if (lat !== 15) begin errors++; $display("FAIL ignore_latency: got %0d expected 15", lat); end
        if (res !== 14'h0019) begin errors++; $display("FAIL ignore_value: got %h expected 0019", res); end
        send(16'h0100);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got %b expected 1", busy); end
        wait_done(1, lat, res, e, bc);
        checks += 2;
        if (lat !== 15) begin errors++; $display("FAIL b2b_latency: got %0d expected 15", lat); end
        if (res !== 14'h0064) begin errors++; $display("FAIL b2b_value: got %h expected 0064", res); end
    endtask

    task automatic test_reset_abort;
        int lat, bc, pulses;
        logic [13:0] res;
        logic e;
        @(negedge clk);
        send(16'h0500);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks += 1;
        if ({busy, done, bin_out, err} !== 17'h0) begin
            errors++; $display("FAIL abort_outputs: got %h expected 0", {busy, done, bin_out, err});
        end
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        checks += 1;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", pulses); end
        run_conv(16'h0500, lat, res, e, bc);
        checks += 2;
        if (res !== 14'h01F4) begin errors++; $display("FAIL abort_fresh_value: got %h expected 01f4", res); end
        if (lat !== 15) begin errors++; $display("FAIL abort_fresh_latency: got %0d expected 15", lat); end
    endtask

    task automatic test_sweep;
        int lat, bc;
        logic [13:0] res;
        logic e;
        int d0, d1, d2, d3, expv;
        for (int i = 0; i < 1000; i++) begin
            d0 = $urandom_range(0, 9);
            d1 = $urandom_range(0, 9);
            d2 = $urandom_range(0, 9);
            d3 = $urandom_range(0, 9);
            expv = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
            run_conv({d3[3:0], d2[3:0], d1[3:0], d0[3:0]}, lat, res, e, bc);
            checks += 1;
            if (res !== expv[13:0] || e !== 1'b0 || lat !== 15) begin
                errors++;
                $display("FAIL sweep_%0d%0d%0d%0d: got %0d err=%b lat=%0d expected %0d err=0 lat=15",
                         d3, d2, d1, d0, res, e, lat, expv);
            end
        end
    endtask

    task automatic test_two_digit;
        logic [7:0] vecs [2];
        logic [6:0] exps [2];
        int lat;
        logic [6:0] res;
        logic e;
        vecs[0] = 8'h99; exps[0] = 7'h63;
        vecs[1] = 8'h47; exps[1] = 7'h2F;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start2  = 1'b1;
            bcd_in2 = vecs[k];
            @(negedge clk);
            start2  = 1'b0;
            lat = -1;
            res = '0;
            e = 1'b0;
            for (int n = 1; n < 30; n++) begin
                if (done2) begin
                    lat = n;
                    res = bin_out2;
                    e = err2;
                    break;
                end
                @(negedge clk);
            end
            checks += 3;
            if (lat !== 8) begin errors++; $display("FAIL d2_latency_%h: got %0d expected 8", vecs[k], lat); end
            if (res !== exps[k]) begin errors++; $display("FAIL d2_value_%h: got %h expected %h", vecs[k], res, exps[k]); end
            if (e !== 1'b0) begin errors++; $display("FAIL d2_err_%h: got %b expected 0", vecs[k], e); end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        bcd_in  = '0;
        start2  = 1'b0;
        bcd_in2 = '0;
        test_reset;
        test_max;
        test_values;
        test_invalid;
        test_back_to_back;
        test_reset_abort;
        test_two_digit;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
